// File: rtl/divsub_pkg.sv
// rtl/divsub_pkg.sv - shared state encoding and default width for the repeated-subtraction divider
package divsub_pkg;

   localparam int DIVSUB_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } divsub_state_t;

endpackage

// File: rtl/sub_cmp.sv
// rtl/sub_cmp.sv - combinational subtractor returning a-b and a>=b from the borrow-out
module sub_cmp
   import divsub_pkg::*;
#(
   parameter int WIDTH = DIVSUB_WIDTH
)
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             ge
);

   logic borrow;

   // One extra bit on the subtraction captures the borrow; no borrow means a >= b.
   always_comb begin
      {borrow, diff} = {1'b0, a} - {1'b0, b};
      ge = ~borrow;
   end

endmodule

// File: rtl/div_repeated_sub.sv
// rtl/div_repeated_sub.sv - sequential unsigned divider by repeated subtraction (optional abort: DIVSUB_ABORT_EN)
module div_repeated_sub
   import divsub_pkg::*;
#(
   parameter int WIDTH = DIVSUB_WIDTH
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef DIVSUB_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   divsub_state_t state;
   divsub_state_t state_nxt;

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] quo;
   logic             dbz;
   logic [WIDTH-1:0] diff;
   logic             ge;
   logic             abort_hit;

`ifdef DIVSUB_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   sub_cmp #(.WIDTH(WIDTH)) u_sub_cmp (
      .a    (rem),
      .b    (dsr),
      .diff (diff),
      .ge   (ge)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: a zero divisor skips SUB; abort in SUB beats the final compare-fail.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (divisor == '0) ? DONE : SUB;
            end
         end
         SUB: begin
            if (abort_hit) begin
               state_nxt = IDLE;
            end else if (!ge) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch operands on start, then subtract once per cycle while rem >= dsr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem <= '0;
         dsr <= '0;
         quo <= '0;
         dbz <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  rem <= dividend;
                  dsr <= divisor;
                  if (divisor == '0) begin
                     quo <= '1;
                     dbz <= 1'b1;
                  end else begin
                     quo <= '0;
                     dbz <= 1'b0;
                  end
               end
            end
            SUB: begin
               if (abort_hit) begin
                  rem <= '0;
                  quo <= '0;
                  dbz <= 1'b0;
               end else if (ge) begin
                  rem <= diff;
                  quo <= quo + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status flags decode straight from the registered state, so they are glitch-free.
   always_comb begin
      busy        = (state == SUB) || (state == DONE);
      done        = (state == DONE);
      quotient    = quo;
      remainder   = rem;
      div_by_zero = dbz;
   end

endmodule

// File: tb/tb_div_repeated_sub.sv
// tb/tb_div_repeated_sub.sv - self-checking bench for div_repeated_sub (abort sequence built with DIVSUB_ABORT_EN)
module tb_div_repeated_sub;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
`ifdef DIVSUB_ABORT_EN
   logic        abort;
`endif
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int checks = 0;
   int failures = 0;

   div_repeated_sub #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef DIVSUB_ABORT_EN
      .abort       (abort),
`endif
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      int          lat;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic edz,
                          input int elat);
      int cyc;
      int busy_cnt;
      bit seen;
      @(negedge clk);
      start = 1'b1;
      dividend = a;
      divisor = b;
      cyc = 0;
      busy_cnt = 0;
      seen = 0;
      while (!seen && cyc < 70000) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (busy) busy_cnt++;
         if (done) seen = 1;
      end
      check({tag, " done_seen"}, seen, 1);
      check({tag, " latency"}, cyc, elat);
      check({tag, " busy_cycles"}, busy_cnt, elat);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, div_by_zero, edz);
      dividend = 16'($urandom);
      divisor = 16'($urandom);
      @(negedge clk);
      check({tag, " done_one_cycle"}, done, 0);
      check({tag, " idle_after"}, busy, 0);
      check({tag, " quotient_held"}, quotient, eq);
      check({tag, " remainder_held"}, remainder, er);
   endtask

   task automatic run_model(input string tag, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] eq;
      logic [15:0] er;
      int elat;
      if (b == 16'd0) begin
         eq = 16'hFFFF;
         er = a;
         elat = 1;
      end else begin
         eq = a / b;
         er = a % b;
         elat = int'(eq) + 2;
      end
      run_div(tag, a, b, eq, er, (b == 16'd0), elat);
   endtask

   vec_t vecs[$];

   initial begin
      int cyc;
      bit seen;
      vecs.push_back('{16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 16});
      vecs.push_back('{16'd5,     16'd9,     16'd0,     16'd5,     1'b0, 2});
      vecs.push_back('{16'd0,     16'd3,     16'd0,     16'd0,     1'b0, 2});
      vecs.push_back('{16'd9,     16'd9,     16'd1,     16'd0,     1'b0, 3});
      vecs.push_back('{16'hFFFF,  16'd0,     16'hFFFF,  16'hFFFF,  1'b1, 1});
      vecs.push_back('{16'd8,     16'd2,     16'd4,     16'd0,     1'b0, 6});
      vecs.push_back('{16'd0,     16'd0,     16'hFFFF,  16'd0,     1'b1, 1});
      vecs.push_back('{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0, 3});
      vecs.push_back('{16'hFFFE,  16'hFFFF,  16'd0,     16'hFFFE,  1'b0, 2});
      vecs.push_back('{16'hFFFF,  16'h0101,  16'd255,   16'd0,     1'b0, 257});

      rst_n = 1'b0;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
`ifdef DIVSUB_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset div_by_zero", div_by_zero, 0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                 vecs[i].dz, vecs[i].lat);
      end

      // start while busy is ignored, and operand changes during the run are not picked up
      @(negedge clk);
      start = 1'b1;
      dividend = 16'd50;
      divisor = 16'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      dividend = 16'd7;
      divisor = 16'd7;
      @(negedge clk);
      start = 1'b0;
      cyc = 4;
      seen = done;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1;
      end
      check("busy_start done_seen", seen, 1);
      check("busy_start latency", cyc, 12);
      check("busy_start quotient", quotient, 10);
      check("busy_start remainder", remainder, 0);
      @(negedge clk);
      check("busy_start no_requeue", busy, 0);
      run_div("after_busy", 16'd7, 16'd7, 16'd1, 16'd0, 1'b0, 3);

      // asynchronous reset mid-division
      @(negedge clk);
      start = 1'b1;
      dividend = 16'd1000;
      divisor = 16'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("pre_reset busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async busy", busy, 0);
      check("async done", done, 0);
      check("async quotient", quotient, 0);
      check("async remainder", remainder, 0);
      check("async div_by_zero", div_by_zero, 0);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) seen = 1;
      end
      check("reset_hold quiet", seen, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_reset quiet", busy, 0);
      run_div("post_reset", 16'd10, 16'd4, 16'd2, 16'd2, 1'b0, 4);

`ifdef DIVSUB_ABORT_EN
      @(negedge clk);
      start = 1'b1;
      dividend = 16'd200;
      divisor = 16'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort quotient", quotient, 0);
      check("abort remainder", remainder, 0);
      check("abort div_by_zero", div_by_zero, 0);
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("abort no_done", seen, 0);
      run_div("after_abort", 16'd13, 16'd4, 16'd3, 16'd1, 1'b0, 5);
`endif

      for (int i = 0; i < 40; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom_range(0, 600));
         rb = 16'($urandom_range(0, 64));
         if (i % 8 == 7) rb = 16'($urandom);
         if (i % 8 == 3) ra = 16'($urandom);
         if (i % 8 == 3 && rb < 16'd64) rb = rb + 16'd64;
         run_model($sformatf("rand%0d_%0d_%0d", i, ra, rb), ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
